// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid core front end.
// Used by fetch_unit and fetch_fifo.
package rapid_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {instr, pc} entries.
// Head entry reads as zero while the FIFO is empty.
module fetch_fifo
    import rapid_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output T              o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = (r_count != '0) ? r_mem[r_rd] : T'('0);

    // Storage needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy; flush empties in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, redirect flush.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned     XLEN     = rapid_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = rapid_pkg::RESET_PC,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_out,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] program_counter_o,
    output logic            fetch_misaligned
);

    import rapid_pkg::*;

    localparam int unsigned     CW   = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [XLEN-1:0] w_target;
    logic            w_halted;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_keep;
    logic            w_pop;
    logic [CW:0]     w_credit;
    logic [CW-1:0]   w_count;
    logic            w_full;
    entry_t          w_wdata;
    entry_t          w_head;

    assign w_target = {pc_out[XLEN-1:2], 2'b00};

    // Outstanding requests plus buffered words never exceed DEPTH,
    // so every response always has a FIFO slot.
    assign w_credit = {1'b0, r_inflight} + {1'b0, w_count};

    assign imem_req_valid = reset_n && !pc_load && !w_halted
                          && (w_credit < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = (r_drop != '0);
    assign w_keep     = imem_rsp_valid && !w_rsp_drop && !pc_load;

    assign dec_valid         = (w_count != '0);
    assign w_pop             = dec_valid && dec_ready && !pc_load;
    assign instruction       = w_head.instr;
    assign program_counter_o = w_head.pc;

    assign w_wdata.instr = imem_rsp_data;
    assign w_wdata.pc    = r_rsp_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_keep),
        .i_data  (w_wdata),
        .i_pop   (w_pop),
        .i_flush (pc_load),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // Request and response program counters; a redirect retargets both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (pc_load) begin
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + STEP;
            end
            if (w_keep) begin
                r_rsp_pc <= r_rsp_pc + STEP;
            end
        end
    end

    // In-flight tracking; on redirect everything still outstanding
    // becomes a drop, and the response landing now is discarded too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (pc_load) begin
            r_inflight <= r_inflight - CW'(imem_rsp_valid);
            r_drop     <= r_inflight - CW'(imem_rsp_valid);
        end else begin
            r_inflight <= r_inflight + CW'(w_req_fire)
                        - CW'(imem_rsp_valid);
            if (imem_rsp_valid && w_rsp_drop) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_halted;

    // Misaligned redirect target halts fetch until an aligned one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_halted <= 1'b0;
        end else if (pc_load) begin
            r_halted <= (pc_out[1:0] != 2'b00);
        end
    end

    assign w_halted         = r_halted;
    assign fetch_misaligned = r_halted;
`else
    logic w_unused_lo;

    assign w_unused_lo      = ^pc_out[1:0];
    assign w_halted         = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_n) !(w_keep && w_full));

    a_no_orphan_rsp: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && (r_inflight == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order latency memory.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pc_load = 1'b0;
    logic [31:0] pc_out = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] program_counter_o;
    logic        fetch_misaligned;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .pc_load           (pc_load),
        .pc_out            (pc_out),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .instruction       (instruction),
        .program_counter_o (program_counter_o),
        .fetch_misaligned  (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: accepted request at cycle c answers in cycle c+lat.
    initial begin
        mreq_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                mq.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + lat;
                mq.push_back(r);
            end
            cyc++;
            @(negedge clk);
            if (!reset_n) mq.delete();
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_at(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    task automatic apply_reset(input int l);
        @(negedge clk);
        reset_n        = 1'b0;
        pc_load        = 1'b0;
        pc_out         = '0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        lat            = l;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, imem_req_addr, dec_valid, instruction,
             program_counter_o, fetch_misaligned} !== 99'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rv=%b a=%h dv=%b i=%h pc=%h m=%b want all 0",
                     imem_req_valid, imem_req_addr, dec_valid,
                     instruction, program_counter_o, fetch_misaligned);
        end
    endtask

    task automatic test_stream();
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
                n_bad++;
                $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h",
                         c, imem_req_valid, imem_req_addr, 32'(4 * c));
            end
            n_cmp++;
            if (dec_valid !== (c >= 2)) begin
                n_bad++;
                $display("FAIL stream_dv c%0d: got %b want %b",
                         c, dec_valid, (c >= 2));
            end
            if (c >= 2) begin
                n_cmp++;
                if (program_counter_o !== 32'(4 * (c - 2)) ||
                    instruction !== word_at(32'(4 * (c - 2)))) begin
                    n_bad++;
                    $display("FAIL stream_head c%0d: got pc=%h i=%h want pc=%h i=%h",
                             c, program_counter_o, instruction,
                             32'(4 * (c - 2)), word_at(32'(4 * (c - 2))));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int          nreq;
        int          npop;
        logic [31:0] exp;
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        nreq = 0;
        repeat (10) begin
            #1;
            if (imem_req_valid && imem_req_ready) nreq++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (nreq != DEPTH) begin
            n_bad++;
            $display("FAIL stall_reqs: got %0d want %0d", nreq, DEPTH);
        end
        n_cmp++;
        if (dec_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_full: got dv=%b rv=%b want dv=1 rv=0",
                     dec_valid, imem_req_valid);
        end
        dec_ready = 1'b1;
        exp  = 32'h0;
        npop = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (dec_valid) begin
                n_cmp++;
                if (program_counter_o !== exp || instruction !== word_at(exp)) begin
                    n_bad++;
                    $display("FAIL stall_drain: got pc=%h i=%h want pc=%h i=%h",
                             program_counter_o, instruction, exp, word_at(exp));
                end
                exp = exp + 32'd4;
                npop++;
            end
        end
        n_cmp++;
        if (npop < 4) begin
            n_bad++;
            $display("FAIL stall_popcount: got %0d want >=4", npop);
        end
        @(negedge clk);
    endtask

    task automatic test_redirect_inflight();
        int wait_c;
        apply_reset(3);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        repeat (3) @(negedge clk);
        pc_load = 1'b1;
        pc_out  = 32'h100;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_noreq: got %b want 0", imem_req_valid);
        end
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL redir_req: got v=%b a=%h want v=1 a=100",
                     imem_req_valid, imem_req_addr);
        end
        wait_c = -1;
        for (int i = 0; i < 12 && wait_c < 0; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (dec_valid) wait_c = i;
        end
        n_cmp++;
        if (wait_c != 4) begin
            n_bad++;
            $display("FAIL redir_latency: got %0d want 4", wait_c);
        end
        n_cmp++;
        if (program_counter_o !== 32'h100 || instruction !== word_at(32'h100)) begin
            n_bad++;
            $display("FAIL redir_head: got pc=%h i=%h want pc=100 i=%h",
                     program_counter_o, instruction, word_at(32'h100));
        end
        @(negedge clk);
    endtask

    task automatic test_redirect_same_cycle();
        int wait_c;
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (dec_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL same_pre: got dv=%b rsp=%b want 1 1",
                     dec_valid, imem_rsp_valid);
        end
        pc_load = 1'b1;
        pc_out  = 32'h40;
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        n_cmp++;
        if (dec_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL same_flush: got dv=%b want 0", dec_valid);
        end
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            n_bad++;
            $display("FAIL same_req: got v=%b a=%h want v=1 a=40",
                     imem_req_valid, imem_req_addr);
        end
        wait_c = -1;
        for (int i = 0; i < 10 && wait_c < 0; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (dec_valid) wait_c = i;
        end
        n_cmp++;
        if (wait_c != 2 || program_counter_o !== 32'h40) begin
            n_bad++;
            $display("FAIL same_head: got t=%0d pc=%h want t=2 pc=40",
                     wait_c, program_counter_o);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        int          got;
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        pc_load = 1'b1;
        pc_out  = 32'hFFFF_FFFC;
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffffc",
                     imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_req1: got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        exp = 32'hFFFF_FFFC;
        got = 0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (dec_valid) begin
                n_cmp++;
                if (program_counter_o !== exp || instruction !== word_at(exp)) begin
                    n_bad++;
                    $display("FAIL wrap_head: got pc=%h i=%h want pc=%h i=%h",
                             program_counter_o, instruction, exp, word_at(exp));
                end
                exp = exp + 32'd4;
                got++;
            end
        end
        n_cmp++;
        if (got != 2) begin
            n_bad++;
            $display("FAIL wrap_timeout: got %0d want 2", got);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        logic [31:0] exp;
        int          wait_c;
        int          leaks;
        apply_reset(1);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        repeat (3) @(negedge clk);
        pc_load = 1'b1;
        pc_out  = 32'h102;
        @(negedge clk);
        pc_load = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++;
        if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_trap: got m=%b rv=%b want m=1 rv=0",
                     fetch_misaligned, imem_req_valid);
        end
        leaks = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (imem_req_valid || dec_valid || !fetch_misaligned) leaks++;
        end
        n_cmp++;
        if (leaks != 0) begin
            n_bad++;
            $display("FAIL mis_halt: got %0d active cycles want 0", leaks);
        end
        pc_load = 1'b1;
        pc_out  = 32'h200;
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        exp = 32'h200;
`else
        leaks = 0;
        exp   = 32'h100;
`endif
        n_cmp++;
        if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== exp) begin
            n_bad++;
            $display("FAIL mis_resume: got m=%b v=%b a=%h want m=0 v=1 a=%h",
                     fetch_misaligned, imem_req_valid, imem_req_addr, exp);
        end
        wait_c = -1;
        for (int i = 0; i < 10 && wait_c < 0; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (dec_valid) wait_c = i;
        end
        n_cmp++;
        if (wait_c < 0 || program_counter_o !== exp || instruction !== word_at(exp)) begin
            n_bad++;
            $display("FAIL mis_head: got t=%0d pc=%h i=%h want pc=%h i=%h",
                     wait_c, program_counter_o, instruction, exp, word_at(exp));
        end
        @(negedge clk);
    endtask

    // Program-order model: after any redirect the decoder must see
    // target, target+4, ... and memory must see the same address run.
    task automatic test_random();
        logic [31:0] tmp;
        logic [31:0] exp_req;
        logic [31:0] exp_dec;
        logic        m_halt;
        for (int r = 0; r < 3; r++) begin
            apply_reset(int'($urandom_range(1, 4)));
            exp_req = 32'h0;
            exp_dec = 32'h0;
            m_halt  = 1'b0;
            for (int t = 0; t < 400; t++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                dec_ready      = ($urandom_range(0, 2) != 0);
                pc_load        = ($urandom_range(0, 19) == 0);
                tmp = $urandom;
                if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
                pc_out = tmp;
                #1;
                n_cmp++;
                if (fetch_misaligned !== m_halt) begin
                    n_bad++;
                    $display("FAIL rnd_flag r%0d t%0d: got %b want %b",
                             r, t, fetch_misaligned, m_halt);
                end
                n_cmp++;
                if (imem_req_valid &&
                    (pc_load || m_halt || imem_req_addr !== exp_req)) begin
                    n_bad++;
                    $display("FAIL rnd_req r%0d t%0d: got a=%h want a=%h ld=%b halt=%b",
                             r, t, imem_req_addr, exp_req, pc_load, m_halt);
                end
                n_cmp++;
                if (mq.size() > DEPTH) begin
                    n_bad++;
                    $display("FAIL rnd_credit r%0d t%0d: got %0d outstanding want <=%0d",
                             r, t, mq.size(), DEPTH);
                end
                if (m_halt) begin
                    n_cmp++;
                    if (dec_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL rnd_halt_dv r%0d t%0d: got %b want 0",
                                 r, t, dec_valid);
                    end
                end
                if (dec_valid && dec_ready && !pc_load) begin
                    n_cmp++;
                    if (program_counter_o !== exp_dec ||
                        instruction !== word_at(exp_dec)) begin
                        n_bad++;
                        $display("FAIL rnd_dec r%0d t%0d: got pc=%h i=%h want pc=%h i=%h",
                                 r, t, program_counter_o, instruction,
                                 exp_dec, word_at(exp_dec));
                    end
                    exp_dec = exp_dec + 32'd4;
                end
                if (imem_req_valid && imem_req_ready) exp_req = exp_req + 32'd4;
                if (pc_load) begin
                    exp_req = {tmp[31:2], 2'b00};
                    exp_dec = {tmp[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
                    m_halt = (tmp[1:0] != 2'b00);
`endif
                end
                @(negedge clk);
            end
            pc_load = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_wrap();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
